// File: rtl/key_event_ctrl.sv
// Key event controller for a 4-key panel: it synchronises and debounces the keys, generates press, release and
// long events, and queues them through a round-robin arbiter into a FWFT FIFO. Define KEY_EVT_REPEAT_EN for auto-repeat.
module key_event_ctrl #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key,
    output logic [3:0] key_state,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic [1:0] evt_type,
    output logic       evt_drop
);
    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW       = $clog2(DEBOUNCE_MS + 1);
    localparam int HW       = $clog2(LONG_MS + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_LONG    = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_LONG} state_t;

    if (TICK_DIV < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        DEBOUNCE_MS < 1 || LONG_MS < 1 || REPEAT_MS < 1) begin : g_bad_cfg
        $error("key_event_ctrl: unsupported parameter set");
    end

    logic [3:0]    r_sync1, r_sync2, r_stable;
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic [DW-1:0] r_db_cnt   [4];
    logic [HW-1:0] r_hold_cnt [4];
    state_t        r_state    [4];
    logic [3:0]    w_flip, w_evt_vld;
    logic [1:0]    w_evt_type [4];
    logic [3:0]    r_pend_vld;
    logic [1:0]    r_pend_type [4];
    logic [1:0]    r_rr_ptr, w_gnt_idx;
    logic          w_gnt_vld, w_push, w_pop, w_full, w_empty;
    logic          r_drop;
    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr;
`ifdef KEY_EVT_REPEAT_EN
    localparam int RW = $clog2(REPEAT_MS + 1);
    logic [RW-1:0] r_rep_cnt [4];
`endif

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    // Pins are active low; everything downstream works in "1 = pressed".
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= ~key;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_flip[k]     = w_tick && (r_sync2[k] != r_stable[k]) && (r_db_cnt[k] == DW'(DEBOUNCE_MS - 1));
            w_evt_vld[k]  = 1'b0;
            w_evt_type[k] = EVT_PRESS;
            case (r_state[k])
                ST_IDLE: w_evt_vld[k] = w_flip[k] && !r_stable[k];
                ST_PRESSED: begin
                    if (w_flip[k]) begin
                        w_evt_vld[k]  = 1'b1;
                        w_evt_type[k] = EVT_RELEASE;
                    end else if (w_tick && r_hold_cnt[k] == HW'(LONG_MS - 1)) begin
                        w_evt_vld[k]  = 1'b1;
                        w_evt_type[k] = EVT_LONG;
                    end
                end
                ST_LONG: begin
                    if (w_flip[k]) begin
                        w_evt_vld[k]  = 1'b1;
                        w_evt_type[k] = EVT_RELEASE;
`ifdef KEY_EVT_REPEAT_EN
                    end else if (w_tick && r_rep_cnt[k] == RW'(REPEAT_MS - 1)) begin
                        w_evt_vld[k]  = 1'b1;
                        w_evt_type[k] = EVT_LONG;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_stable <= '0;
            for (int k = 0; k < 4; k++) begin
                r_db_cnt[k]   <= '0;
                r_hold_cnt[k] <= '0;
                r_state[k]    <= ST_IDLE;
`ifdef KEY_EVT_REPEAT_EN
                r_rep_cnt[k]  <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (r_sync2[k] == r_stable[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (w_flip[k]) begin
                    r_stable[k] <= ~r_stable[k];
                    r_db_cnt[k] <= '0;
                end else if (w_tick) begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end

                // Hold time counts from the press event and saturates at LONG_MS.
                if (r_state[k] == ST_IDLE)
                    r_hold_cnt[k] <= '0;
                else if (w_tick && r_hold_cnt[k] != HW'(LONG_MS))
                    r_hold_cnt[k] <= r_hold_cnt[k] + 1'b1;

`ifdef KEY_EVT_REPEAT_EN
                if (r_state[k] != ST_LONG)
                    r_rep_cnt[k] <= '0;
                else if (w_tick)
                    r_rep_cnt[k] <= (r_rep_cnt[k] == RW'(REPEAT_MS - 1)) ? '0 : r_rep_cnt[k] + 1'b1;
`endif

                case (r_state[k])
                    ST_IDLE:    if (w_evt_vld[k]) r_state[k] <= ST_PRESSED;
                    ST_PRESSED: if (w_flip[k]) r_state[k] <= ST_IDLE;
                                else if (w_evt_vld[k]) r_state[k] <= ST_LONG;
                    ST_LONG:    if (w_flip[k]) r_state[k] <= ST_IDLE;
                    default:    r_state[k] <= ST_IDLE;
                endcase
            end
        end
    end

    // Round-robin: scanning from the far end leaves the key nearest the pointer as the winner.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pend_vld[r_rr_ptr + 2'(i)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = r_rr_ptr + 2'(i);
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && evt_ready;
    assign w_push  = w_gnt_vld && (!w_full || w_pop);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pend_vld <= '0;
            r_drop     <= 1'b0;
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int k = 0; k < 4; k++) r_pend_type[k] <= EVT_PRESS;
        end else begin
            // An occupied slot keeps its older event; the newcomer is dropped.
            for (int k = 0; k < 4; k++) begin
                if (w_push && w_gnt_idx == 2'(k)) r_pend_vld[k] <= 1'b0;
                if (w_evt_vld[k] && !r_pend_vld[k]) begin
                    r_pend_vld[k]  <= 1'b1;
                    r_pend_type[k] <= w_evt_type[k];
                end
            end
            r_drop <= |(w_evt_vld & r_pend_vld);
            if (w_push) begin
                r_rr_ptr <= w_gnt_idx + 2'd1;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the FIFO storage has no reset; the outputs are masked while empty instead.
    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {r_pend_type[w_gnt_idx], w_gnt_idx};
    end

    assign key_state = r_stable;
    assign evt_valid = !w_empty;
    assign evt_code  = w_empty ? 2'b00 : r_mem[r_rd_ptr[AW-1:0]][1:0];
    assign evt_type  = w_empty ? 2'b00 : r_mem[r_rd_ptr[AW-1:0]][3:2];
    assign evt_drop  = r_drop;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: an event-level reference model is compared every cycle,
// and directed scenarios are pinned with literal expectations. Honours KEY_EVT_REPEAT_EN.
module tb_key_event_ctrl;
    localparam int TDIV  = 10;
    localparam int DEB   = 2;
    localparam int LNG   = 10;
    localparam int REP   = 3;
    localparam int DEPTH = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] key = 4'hF;
    logic       evt_ready = 1'b1;
    logic [3:0] key_state;
    logic       evt_valid, evt_drop;
    logic [1:0] evt_code, evt_type;

    key_event_ctrl #(
        .CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(DEB), .LONG_MS(LNG), .REPEAT_MS(REP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key), .key_state(key_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_type(evt_type), .evt_drop(evt_drop)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    int         m_tcnt, m_ptr, cyc;
    logic [3:0] m_sync1, m_sync2, m_stable, m_pend_v;
    int         m_run [4];
    int         m_hold [4];
    bit         m_held [4];
    logic [1:0] m_pend_t [4];
    logic [3:0] m_fifo [$];
    logic       m_drop;

    always @(posedge sys_clk or negedge sys_rst_n) begin : model
        bit         tick, pop, can;
        bit         ev_v [4];
        logic [1:0] ev_t [4];
        logic [3:0] pre;
        int         g;
        if (!sys_rst_n) begin
            m_tcnt = 0; m_ptr = 0; m_sync1 = 0; m_sync2 = 0; m_stable = 0; m_pend_v = 0;
            m_drop = 0; m_fifo.delete();
            for (int k = 0; k < 4; k++) begin
                m_run[k] = 0; m_hold[k] = 0; m_held[k] = 0; m_pend_t[k] = 0;
            end
        end else begin
            cyc++;
            tick = (m_tcnt == TDIV - 1);
            pop  = (m_fifo.size() != 0) && evt_ready;
            for (int k = 0; k < 4; k++) begin
                ev_v[k] = 0; ev_t[k] = 2'b00;
                if (m_sync2[k] != m_stable[k]) begin
                    if (tick) m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_run[k] = 0;
                        m_stable[k] = ~m_stable[k];
                        ev_v[k] = 1;
                        ev_t[k] = m_stable[k] ? 2'b01 : 2'b10;
                        m_held[k] = m_stable[k];
                        m_hold[k] = 0;
                    end else if (m_held[k] && tick) begin
                        m_hold[k]++;
                    end
                end else begin
                    m_run[k] = 0;
                    if (m_held[k] && tick) m_hold[k]++;
                end
                if (!ev_v[k] && m_held[k] && tick) begin
                    if (m_hold[k] == LNG) begin ev_v[k] = 1; ev_t[k] = 2'b11; end
`ifdef KEY_EVT_REPEAT_EN
                    else if (m_hold[k] > LNG && (m_hold[k] - LNG) % REP == 0) begin ev_v[k] = 1; ev_t[k] = 2'b11; end
`endif
                end
            end
            can = (m_fifo.size() < DEPTH) || pop;
            g = -1;
            if (can)
                for (int i = 0; i < 4; i++)
                    if (g < 0 && m_pend_v[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
            if (pop) void'(m_fifo.pop_front());
            if (g >= 0) begin
                m_fifo.push_back({m_pend_t[g], 2'(g)});
                m_ptr = (g + 1) % 4;
            end
            pre = m_pend_v;
            m_drop = 0;
            for (int k = 0; k < 4; k++) if (ev_v[k] && pre[k]) m_drop = 1;
            if (g >= 0) m_pend_v[g] = 0;
            for (int k = 0; k < 4; k++)
                if (ev_v[k] && !pre[k]) begin m_pend_v[k] = 1; m_pend_t[k] = ev_t[k]; end
            m_sync2 = m_sync1;
            m_sync1 = ~key;
            m_tcnt  = (m_tcnt + 1) % TDIV;
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    typedef struct { int code; int typ; int cy; } ev_rec_t;
    ev_rec_t log_q [$];
    int      drop_cnt = 0;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            check("key_state", 32'(key_state), 32'(m_stable));
            check("evt_valid", 32'(evt_valid), 32'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                check("evt_code", 32'(evt_code), 32'(m_fifo[0][1:0]));
                check("evt_type", 32'(evt_type), 32'(m_fifo[0][3:2]));
            end
            check("evt_drop", 32'(evt_drop), 32'(m_drop));
            if (evt_valid && evt_ready) log_q.push_back('{int'(evt_code), int'(evt_type), cyc});
            if (evt_drop) drop_cnt++;
        end
    end

    // ---------------- stimulus helpers (inputs change 1 ns after posedge) ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic align_tick();
        for (int i = 0; i < 2 * TDIV; i++) begin
            cycles(1);
            if (m_tcnt == 0) break;
        end
    endtask

    task automatic do_reset();
        cycles(1);
        sys_rst_n = 1'b0;
        cycles(3);
        sys_rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge sys_clk);
        check({name, "_key_state"}, 32'(key_state), 0);
        check({name, "_evt_valid"}, 32'(evt_valid), 0);
        check({name, "_evt_code"}, 32'(evt_code), 0);
        check({name, "_evt_type"}, 32'(evt_type), 0);
        check({name, "_evt_drop"}, 32'(evt_drop), 0);
    endtask

    task automatic check_log(input string name, input int idx, input int code, input int typ);
        if (idx < log_q.size()) begin
            check({name, "_code"}, 32'(log_q[idx].code), 32'(code));
            check({name, "_type"}, 32'(log_q[idx].typ), 32'(typ));
        end else begin
            check({name, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        cyc = 0;
        // Reset state
        check_reset_outputs("reset");
        cycles(2);
        sys_rst_n = 1'b1;
        cycles(20);

        // Bounce rejection: 15 cycles low never spans two ticks when aligned to a tick
        align_tick();
        log_q.delete();
        key = 4'b1101;
        cycles(15);
        key = 4'hF;
        cycles(60);
        check("bounce_events", 32'(log_q.size()), 0);
        check("bounce_state", 32'(key_state), 0);

        // Short press on key 2
        align_tick();
        log_q.delete();
        key = 4'b1011;
        cycles(45);
        @(negedge sys_clk);
        check("short_state", 32'(key_state), 32'b0100);
        cycles(15);
        key = 4'hF;
        cycles(60);
        check("short_events", 32'(log_q.size()), 2);
        check_log("short0", 0, 2, 1);
        check_log("short1", 1, 2, 2);

        // Long press on key 0, held 200 cycles
        align_tick();
        log_q.delete();
        key = 4'b1110;
        cycles(200);
        key = 4'hF;
        cycles(60);
        check_log("long_press", 0, 0, 1);
        check_log("long_first", 1, 0, 3);
        if (log_q.size() >= 2) check("long_delay", 32'(log_q[1].cy - log_q[0].cy), 100);
`ifdef KEY_EVT_REPEAT_EN
        check("long_events", 32'(log_q.size()), 6);
        check_log("long_rep1", 2, 0, 3);
        check_log("long_rep3", 4, 0, 3);
        check_log("long_release", 5, 0, 2);
        if (log_q.size() >= 5) check("repeat_period", 32'(log_q[4].cy - log_q[3].cy), 30);
`else
        check("long_events", 32'(log_q.size()), 3);
        check_log("long_release", 2, 0, 2);
`endif

        // Simultaneous press with pointer at 0
        do_reset();
        align_tick();
        log_q.delete();
        key = 4'b0000;
        cycles(40);
        check("simul_events", 32'(log_q.size()), 4);
        for (int i = 0; i < 4; i++) check_log("simul", i, i, 1);
        if (log_q.size() >= 4) check("simul_spacing", 32'(log_q[3].cy - log_q[0].cy), 3);
        key = 4'hF;
        cycles(40);

        // Backpressure and drop
        do_reset();
        evt_ready = 1'b0;
        log_q.delete();
        drop_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            align_tick();
            key = ~(4'b0001 << (k % 4));
            cycles(40);
            key = 4'hF;
            cycles(40);
        end
        @(negedge sys_clk);
        check("bp_drops", 32'(drop_cnt), 3);
        check("bp_valid", 32'(evt_valid), 1);
        check("bp_head_code", 32'(evt_code), 0);
        check("bp_head_type", 32'(evt_type), 1);
        check("bp_no_pops", 32'(log_q.size()), 0);
        cycles(1);
        evt_ready = 1'b1;
        cycles(20);
        check("bp_events", 32'(log_q.size()), 7);
        check_log("bp0", 0, 0, 1);
        check_log("bp1", 1, 0, 2);
        check_log("bp2", 2, 1, 1);
        check_log("bp3", 3, 1, 2);
        check_log("bp4", 4, 2, 1);
        check_log("bp5", 5, 3, 1);
        check_log("bp6", 6, 0, 1);

        // Reset while key 3 is held
        align_tick();
        key = 4'b0111;
        cycles(40);
        log_q.delete();
        sys_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) check_reset_outputs("midrst");
        cycles(1);
        sys_rst_n = 1'b1;
        cycles(40);
        check("midrst_events", 32'(log_q.size()), 1);
        check_log("midrst_press", 0, 3, 1);
        @(negedge sys_clk);
        check("midrst_state", 32'(key_state), 32'b1000);
        cycles(1);
        key = 4'hF;
        cycles(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
